// File: rtl/bka_pipe_addsub.sv
// bka_pipe_addsub: parametrised Brent-Kung adder/subtractor with 1..3 register
// stages and a valid/ready handshake. The pipeline stalls as a whole whenever
// a result is held at the output and not taken; otherwise every stage advances.
module bka_pipe_addsub #(
   parameter int WIDTH       = 32,
   parameter int PIPE_STAGES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] c,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int LG = $clog2(WIDTH);

   logic             advance_s;
   // pre-processing results (next state of the first cut)
   logic [WIDTH-1:0] s1_p_d, s1_g_d;
   logic             s1_cin_d;
   // up-sweep inputs (after the optional first cut)
   logic [WIDTH-1:0] up_p_s, up_g_s;
   logic             up_cin_s, up_v_s;
   // up-sweep results (next state of the second cut)
   logic [WIDTH-1:0] s2_gp_d, s2_gg_d;
   // down-sweep inputs (after the optional second cut)
   logic [WIDTH-1:0] dn_gp_s, dn_gg_s, dn_p_s;
   logic             dn_cin_s, dn_v_s;
   // final carries, sum and flags (next state of the output register)
   logic [WIDTH-1:0] out_c_d, out_s_d;
   logic             out_ovf_d, out_zero_d;
   // output register
   logic [WIDTH-1:0] out_s_q, out_c_q;
   logic             out_v_q, out_ovf_q, out_zero_q;

   // A held, unconsumed result freezes the whole pipe.
   assign advance_s = !(out_v_q && !out_ready);
   assign in_ready  = advance_s;

   // Pre-processing: subtract inverts b and forces the carry-in to one.
   always_comb begin
      if (op) begin
         s1_p_d   = a ^ ~b;
         s1_g_d   = a & ~b;
         s1_cin_d = 1'b1;
      end else begin
         s1_p_d   = a ^ b;
         s1_g_d   = a & b;
         s1_cin_d = cin;
      end
   end

   if (PIPE_STAGES == 3) begin : g_cut1
      logic [WIDTH-1:0] p_q, g_q;
      logic             cin_q, v_q;
      // First cut: hold per-bit propagate/generate and the effective carry-in.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            p_q   <= {WIDTH{1'b0}};
            g_q   <= {WIDTH{1'b0}};
            cin_q <= 1'b0;
            v_q   <= 1'b0;
         end else if (advance_s) begin
            p_q   <= s1_p_d;
            g_q   <= s1_g_d;
            cin_q <= s1_cin_d;
            v_q   <= in_valid;
         end
      end
      assign up_p_s   = p_q;
      assign up_g_s   = g_q;
      assign up_cin_s = cin_q;
      assign up_v_s   = v_q;
   end else begin : g_nocut1
      assign up_p_s   = s1_p_d;
      assign up_g_s   = s1_g_d;
      assign up_cin_s = s1_cin_d;
      assign up_v_s   = in_valid;
   end

   // Up-sweep: carry-in folded into bit 0, then log2(WIDTH) combine levels.
   always_comb begin
      s2_gp_d    = up_p_s;
      s2_gg_d    = up_g_s;
      s2_gg_d[0] = up_g_s[0] | (up_p_s[0] & up_cin_s);
      for (int l = 0; l < LG; l++) begin
         for (int i = (2 ** (l + 1)) - 1; i < WIDTH; i += 2 ** (l + 1)) begin
            s2_gg_d[i] = s2_gg_d[i] | (s2_gp_d[i] & s2_gg_d[i - (2 ** l)]);
            s2_gp_d[i] = s2_gp_d[i] & s2_gp_d[i - (2 ** l)];
         end
      end
   end

   if (PIPE_STAGES >= 2) begin : g_cut2
      logic [WIDTH-1:0] gp_q, gg_q, p_q;
      logic             cin_q, v_q;
      // Second cut: hold group propagate/generate plus what the sum still needs.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            gp_q  <= {WIDTH{1'b0}};
            gg_q  <= {WIDTH{1'b0}};
            p_q   <= {WIDTH{1'b0}};
            cin_q <= 1'b0;
            v_q   <= 1'b0;
         end else if (advance_s) begin
            gp_q  <= s2_gp_d;
            gg_q  <= s2_gg_d;
            p_q   <= up_p_s;
            cin_q <= up_cin_s;
            v_q   <= up_v_s;
         end
      end
      assign dn_gp_s  = gp_q;
      assign dn_gg_s  = gg_q;
      assign dn_p_s   = p_q;
      assign dn_cin_s = cin_q;
      assign dn_v_s   = v_q;
   end else begin : g_nocut2
      assign dn_gp_s  = s2_gp_d;
      assign dn_gg_s  = s2_gg_d;
      assign dn_p_s   = up_p_s;
      assign dn_cin_s = up_cin_s;
      assign dn_v_s   = up_v_s;
   end

   // Down-sweep fills the remaining carry positions, then sum and flags.
   always_comb begin
      out_c_d = dn_gg_s;
      for (int l = LG - 2; l >= 0; l--) begin
         for (int i = (3 * (2 ** l)) - 1; i < WIDTH; i += 2 ** (l + 1)) begin
            out_c_d[i] = out_c_d[i] | (dn_gp_s[i] & out_c_d[i - (2 ** l)]);
         end
      end
      out_s_d    = dn_p_s;
      out_s_d[0] = dn_p_s[0] ^ dn_cin_s;
      for (int i = 1; i < WIDTH; i++) begin
         out_s_d[i] = dn_p_s[i] ^ out_c_d[i - 1];
      end
      out_ovf_d  = out_c_d[WIDTH-1] ^ out_c_d[WIDTH-2];
      out_zero_d = (out_s_d == {WIDTH{1'b0}});
   end

   // Output register: every result field is held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_s_q    <= {WIDTH{1'b0}};
         out_c_q    <= {WIDTH{1'b0}};
         out_ovf_q  <= 1'b0;
         out_zero_q <= 1'b0;
         out_v_q    <= 1'b0;
      end else if (advance_s) begin
         out_s_q    <= out_s_d;
         out_c_q    <= out_c_d;
         out_ovf_q  <= out_ovf_d;
         out_zero_q <= out_zero_d;
         out_v_q    <= dn_v_s;
      end
   end

   assign out_valid = out_v_q;
   assign s         = out_s_q;
   assign c         = out_c_q;
   assign cout      = out_c_q[WIDTH-1];
   assign ovf       = out_ovf_q;
   assign zero      = out_zero_q;

endmodule

// File: tb/tb_bka_pipe_addsub.sv
// Self-checking bench for bka_pipe_addsub: a 16-bit, 3-stage instance driven by
// directed and random streams against an arithmetic reference model, plus a
// grid of small instances covering the width / stage-count combinations.
module tb_bka_pipe_addsub;
   typedef struct packed {
      logic [15:0] s;
      logic [15:0] c;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = 16'h0;
   logic [15:0] b = 16'h0;
   logic        cin = 1'b0;
   logic        op = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] s, c;
   logic        cout, ovf, zero;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bka_pipe_addsub #(.WIDTH(16), .PIPE_STAGES(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid),
      .out_ready(out_ready), .s(s), .c(c), .cout(cout), .ovf(ovf), .zero(zero)
   );

   // Width / stage sweep: a = all ones, b = 0, cin = 1 on every instance.
   logic        sw_in_valid = 1'b0;
   logic [11:0] sw_v, sw_co, sw_ovf, sw_z, sw_ir;
   logic [63:0] sw_s [12];
   logic [63:0] sw_c [12];

   for (genvar wi = 0; wi < 4; wi++) begin : g_w
      for (genvar pi = 1; pi <= 3; pi++) begin : g_p
         localparam int W = (wi == 0) ? 4 : (wi == 1) ? 8 : (wi == 2) ? 32 : 64;
         logic [W-1:0] s_w, c_w;
         bka_pipe_addsub #(.WIDTH(W), .PIPE_STAGES(pi)) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid),
            .in_ready(sw_ir[wi*3+pi-1]), .a({W{1'b1}}), .b({W{1'b0}}),
            .cin(1'b1), .op(1'b0), .out_valid(sw_v[wi*3+pi-1]),
            .out_ready(1'b1), .s(s_w), .c(c_w), .cout(sw_co[wi*3+pi-1]),
            .ovf(sw_ovf[wi*3+pi-1]), .zero(sw_z[wi*3+pi-1])
         );
         assign sw_s[wi*3+pi-1] = 64'(s_w);
         assign sw_c[wi*3+pi-1] = 64'(c_w);
      end
   end

   // Reference: plain integer arithmetic on a + b' + cin'.
   function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic mcin, input logic mop);
      exp_t        e;
      logic [15:0] bp;
      int unsigned ci, m, lo;
      int          sv;
      bp = mop ? ~mb : mb;
      ci = mop ? 32'd1 : {31'd0, mcin};
      for (int i = 0; i < 16; i++) begin
         m  = (32'd1 << (i + 1)) - 32'd1;
         lo = (32'(ma) & m) + (32'(bp) & m) + ci;
         e.c[i] = lo[i+1];
      end
      e.s    = 16'(32'(ma) + 32'(bp) + ci);
      sv     = int'($signed(ma)) + int'($signed(bp)) + int'(ci);
      e.ovf  = (sv > 32767) || (sv < -32768);
      e.cout = e.c[15];
      e.zero = (e.s == 16'h0);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      a = 16'h1234; b = 16'h4321;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++;
         if ({out_valid, s, c, cout, ovf, zero, in_ready} !== {1'b0, 16'h0, 16'h0, 4'b0001}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b s=%h c=%h co=%b ov=%b z=%b rdy=%b, want 0/0000/0000/0/0/0/1",
                     out_valid, s, c, cout, ovf, zero, in_ready);
         end
      end
      rst_n = 1'b1; in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_leak: out_valid=%b after reset, want 0", out_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         tick();
      end
      in_valid = 1'b0; rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
         end
         tick();
      end
   endtask

   task automatic test_directed(input string name, input logic [15:0] ta, input logic [15:0] tb,
                                input logic tcin, input logic top, input exp_t want);
      a = ta; b = tb; cin = tcin; op = top; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         n_vec++;
         if (out_valid !== (j == 3)) begin
            n_err++;
            $display("FAIL %s_latency: cycle %0d out_valid=%b, want %b", name, j, out_valid, (j == 3));
         end
         if (j == 3) begin
            n_vec++;
            if ({s, c, cout, ovf, zero} !== want) begin
               n_err++;
               $display("FAIL %s: got s=%h c=%h co=%b ov=%b z=%b, want s=%h c=%h co=%b ov=%b z=%b",
                        name, s, c, cout, ovf, zero, want.s, want.c, want.cout, want.ovf, want.zero);
            end
         end
         tick();
      end
   endtask

   task automatic run_stream(input string name, input int n, input int pv, input int pr, input bit b2b);
      exp_t        q[$];
      exp_t        f;
      logic [34:0] hold = 35'h0;
      bit          held = 1'b0;
      int          issued = 0;
      int          seen = 0;
      int          cyc = 0;
      while ((issued < n || q.size() != 0 || out_valid === 1'b1) && cyc < 5000) begin
         in_valid  = (issued < n) && ($urandom_range(99) < pv);
         out_ready = ($urandom_range(99) < pr);
         a = 16'($urandom); b = 16'($urandom);
         cin = 1'($urandom); op = 1'($urandom);
         #1;
         n_vec++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            n_err++;
            $display("FAIL %s_in_ready: got %b, want %b", name, in_ready, !(out_valid && !out_ready));
         end
         if (b2b) begin
            n_vec++;
            if (out_valid !== (cyc >= 3 && cyc < 3 + n)) begin
               n_err++;
               $display("FAIL %s_valid_run: cycle %0d out_valid=%b", name, cyc, out_valid);
            end
         end
         if (held) begin
            n_vec++;
            if ({s, c, cout, ovf, zero} !== hold) begin
               n_err++;
               $display("FAIL %s_stall_stable: got %h, want %h", name, {s, c, cout, ovf, zero}, hold);
            end
         end
         if (out_valid === 1'b1) begin
            n_vec++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL %s_spurious: result %h with nothing in flight", name, s);
            end else begin
               f = q[0];
               if ({s, c, cout, ovf, zero} !== f) begin
                  n_err++;
                  $display("FAIL %s_data: beat %0d got s=%h c=%h f=%b%b%b, want s=%h c=%h f=%b%b%b",
                           name, seen, s, c, cout, ovf, zero, f.s, f.c, f.cout, f.ovf, f.zero);
               end
               if (out_ready) begin
                  void'(q.pop_front());
                  seen++;
               end
            end
         end
         held = out_valid && !out_ready;
         hold = {s, c, cout, ovf, zero};
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, op));
            issued++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_vec++;
      if (seen != n || q.size() != 0) begin
         n_err++;
         $display("FAIL %s_count: consumed %0d of %0d, %0d left in flight", name, seen, n, q.size());
      end
   endtask

   task automatic test_sweep();
      int          w, p;
      logic [63:0] mk;
      sw_in_valid = 1'b1;
      tick();
      sw_in_valid = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         for (int k = 0; k < 12; k++) begin
            w  = (k / 3 == 0) ? 4 : (k / 3 == 1) ? 8 : (k / 3 == 2) ? 32 : 64;
            p  = (k % 3) + 1;
            mk = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
            n_vec++;
            if (sw_v[k] !== (j == p) || sw_ir[k] !== 1'b1) begin
               n_err++;
               $display("FAIL sweep_w%0d_p%0d_valid: cycle %0d out_valid=%b in_ready=%b, want %b/1",
                        w, p, j, sw_v[k], sw_ir[k], (j == p));
            end
            if (j == p) begin
               n_vec++;
               if (sw_s[k] !== 64'h0 || sw_c[k] !== mk || sw_co[k] !== 1'b1 ||
                   sw_ovf[k] !== 1'b0 || sw_z[k] !== 1'b1) begin
                  n_err++;
                  $display("FAIL sweep_w%0d_p%0d_data: s=%h c=%h co=%b ov=%b z=%b, want s=0 c=%h co=1 ov=0 z=1",
                           w, p, sw_s[k], sw_c[k], sw_co[k], sw_ovf[k], sw_z[k], mk);
               end
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_directed("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1});
      test_directed("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0});
      test_directed("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, '{16'hFFFE, 16'h0003, 1'b0, 1'b0, 1'b0});
      test_directed("add_cin",   16'h7FFF, 16'h0000, 1'b1, 1'b0, '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0});
      run_stream("back_to_back", 64, 100, 100, 1'b1);
      run_stream("bubbles", 100, 60, 100, 1'b0);
      run_stream("backpressure", 200, 70, 50, 1'b0);
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
